// File: rtl/grass_pixel_fetch_if.sv
// Pixel-fetch bus: VGA coordinates and ROM read data in, ROM address and
// palette-stage outputs back. master = environment (VGA/ROM/palette), slave = fetch block.
interface grass_pixel_fetch_if #(
  parameter int unsigned ADDR_W = 11
);
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              blank_n;
  logic              frame_clk;
  logic              scroll_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_data;
  logic [3:0]        color_idx;
  logic              grass_on;
  logic              pix_valid;

  modport master (
    output DrawX, DrawY, blank_n, frame_clk, scroll_en, rom_data,
    input  rom_addr, color_idx, grass_on, pix_valid
  );

  modport slave (
    input  DrawX, DrawY, blank_n, frame_clk, scroll_en, rom_data,
    output rom_addr, color_idx, grass_on, pix_valid
  );
endinterface

// File: rtl/grass_pixel_fetch.sv
// Grass strip pixel fetch: maps VGA coordinates to a tile ROM address, captures
// the returned palette index two cycles later and flags grass pixels.
// Optional horizontal drift is built only when GRASS_SCROLL_EN is defined.
module grass_pixel_fetch #(
  parameter int unsigned TILE_W      = 64,
  parameter int unsigned TILE_H      = 32,
  parameter int unsigned GRASS_Y_TOP = 416,
  parameter int unsigned SCROLL_STEP = 1,
  parameter int unsigned ADDR_W      = 11
) (
  input logic                Clk,
  input logic                Reset_n,
  grass_pixel_fetch_if.slave bus
);

  localparam int unsigned ColW = $clog2(TILE_W);
  localparam int unsigned RowW = $clog2(TILE_H);
  localparam logic [9:0]  YTop = 10'(GRASS_Y_TOP);
  localparam logic [9:0]  YEnd = 10'(GRASS_Y_TOP + TILE_H);

  logic [ColW-1:0]   scroll_x;
  logic              in_strip;
  logic [9:0]        dy;
  logic [RowW-1:0]   row;
  logic [ColW-1:0]   col;
  logic [ADDR_W-1:0] addr;

  logic [ADDR_W-1:0] rom_addr_q;
  logic              v1, r1;
  logic              v2, r2;
  logic [3:0]        idx2;

`ifdef GRASS_SCROLL_EN
  logic fc_d;
  logic frame_tick;

  assign frame_tick = bus.frame_clk & ~fc_d;

  // Frame edge detect and scroll offset advance; offset wraps at the tile width.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fc_d     <= 1'b0;
      scroll_x <= '0;
    end else begin
      fc_d <= bus.frame_clk;
      if (frame_tick && bus.scroll_en) begin
        scroll_x <= scroll_x + ColW'(SCROLL_STEP);
      end
    end
  end
`else
  assign scroll_x = '0;

  logic unused_scroll;
  assign unused_scroll = ^{bus.frame_clk, bus.scroll_en};
`endif

  // Region test and tile address; col addition wraps naturally in ColW bits.
  always_comb begin
    in_strip = bus.blank_n && (bus.DrawY >= YTop) && (bus.DrawY < YEnd);
    dy       = bus.DrawY - YTop;
    row      = dy[RowW-1:0];
    col      = bus.DrawX[ColW-1:0] + scroll_x;
    addr     = ADDR_W'({row, col});
  end

  logic unused_bits;
  assign unused_bits = ^{dy[9:RowW], bus.DrawX[9:ColW]};

  // Stage 1: issue ROM address, delay visibility and region flags.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr_q <= '0;
      v1         <= 1'b0;
      r1         <= 1'b0;
    end else begin
      rom_addr_q <= in_strip ? addr : '0;
      v1         <= bus.blank_n;
      r1         <= in_strip;
    end
  end

  // Stage 2: capture ROM data; outside the strip the index is forced transparent.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      v2   <= 1'b0;
      r2   <= 1'b0;
      idx2 <= 4'h0;
    end else begin
      v2   <= v1;
      r2   <= r1;
      idx2 <= r1 ? bus.rom_data : 4'h0;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.color_idx = idx2;
  assign bus.pix_valid = v2;
  assign bus.grass_on  = r2 && (idx2 != 4'h0);

endmodule

// File: tb/tb_grass_pixel_fetch.sv
// Scoreboard bench for grass_pixel_fetch: stimulus pushes expected ROM address
// and outputs (tagged with the cycle they are due); a monitor compares them.
module tb_grass_pixel_fetch;

  localparam int TW   = 64;
  localparam int TH   = 32;
  localparam int YTOP = 416;

  logic Clk;
  logic Reset_n;
  int   cyc;
  int   errors;
  int   checks;

  grass_pixel_fetch_if #(.ADDR_W(11)) bus ();

  grass_pixel_fetch #(
    .TILE_W     (64),
    .TILE_H     (32),
    .GRASS_Y_TOP(416),
    .SCROLL_STEP(1),
    .ADDR_W     (11)
  ) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  // Tile ROM model: data follows the registered address within the same cycle.
  logic [3:0] rom [2048];
  assign bus.rom_data = rom[bus.rom_addr];

  typedef struct {
    int due;
    int addr;
  } addr_item_t;

  typedef struct {
    int due;
    int idx;
    int on;
    int valid;
  } out_item_t;

  addr_item_t addr_q[$];
  out_item_t  out_q[$];

  int m_scroll;
  bit prev_fc;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".rom_addr"}, int'(bus.rom_addr), 0);
    chk({tag, ".color_idx"}, int'(bus.color_idx), 0);
    chk({tag, ".grass_on"}, int'(bus.grass_on), 0);
    chk({tag, ".pix_valid"}, int'(bus.pix_valid), 0);
  endtask

  // Apply one pixel now and record what the strip rules say must come out.
  task automatic apply(input int x, input int y, input bit b, input bit fc, input bit se);
    bit in;
    int a;
    int idx;
    addr_item_t ai;
    out_item_t  oi;
    bus.DrawX     = 10'(x);
    bus.DrawY     = 10'(y);
    bus.blank_n   = b;
    bus.frame_clk = fc;
    bus.scroll_en = se;
    in  = b && (y >= YTOP) && (y < YTOP + TH);
    a   = in ? (y - YTOP) * TW + ((x + m_scroll) % TW) : 0;
    idx = in ? int'(rom[a]) : 0;
    ai.due = cyc + 1;
    ai.addr = a;
    addr_q.push_back(ai);
    oi.due = cyc + 2;
    oi.idx = idx;
    oi.on = (in && idx != 0) ? 1 : 0;
    oi.valid = b ? 1 : 0;
    out_q.push_back(oi);
`ifdef GRASS_SCROLL_EN
    if (fc && !prev_fc && se) m_scroll = (m_scroll + 1) % TW;
    prev_fc = fc;
`endif
  endtask

  task automatic drive(input int x, input int y, input bit b, input bit fc, input bit se);
    @(posedge Clk);
    #1;
    apply(x, y, b, fc, se);
  endtask

  task automatic enter_reset(input string tag);
    @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    addr_q.delete();
    out_q.delete();
    m_scroll = 0;
    prev_fc  = 1'b0;
    #1;
    check_zero(tag);
  endtask

  task automatic release_with(input int x, input int y, input bit b);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    apply(x, y, b, 1'b0, 1'b0);
  endtask

  // Monitor: compare whatever expectation falls due this cycle.
  always @(negedge Clk) begin
    addr_item_t ai;
    out_item_t  oi;
    if (addr_q.size() > 0 && addr_q[0].due == cyc) begin
      ai = addr_q.pop_front();
      chk("rom_addr", int'(bus.rom_addr), ai.addr);
    end
    if (out_q.size() > 0 && out_q[0].due == cyc) begin
      oi = out_q.pop_front();
      chk("color_idx", int'(bus.color_idx), oi.idx);
      chk("grass_on", int'(bus.grass_on), oi.on);
      chk("pix_valid", int'(bus.pix_valid), oi.valid);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors   = 0;
    checks   = 0;
    cyc      = 0;
    m_scroll = 0;
    prev_fc  = 1'b0;
    for (int i = 0; i < 2048; i++) rom[i] = 4'($urandom_range(0, 15));
    rom[5]    = 4'h4;
    rom[70]   = 4'h0;
    rom[2047] = 4'h9;
    Reset_n       = 1'b0;
    bus.DrawX     = '0;
    bus.DrawY     = '0;
    bus.blank_n   = 1'b0;
    bus.frame_clk = 1'b0;
    bus.scroll_en = 1'b0;

    // Reset held while inputs toggle: everything stays zero.
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk);
      #1;
      bus.DrawX     = 10'($urandom_range(0, 639));
      bus.DrawY     = 10'($urandom_range(410, 450));
      bus.blank_n   = 1'($urandom_range(0, 1));
      bus.frame_clk = 1'($urandom_range(0, 1));
      bus.scroll_en = 1'($urandom_range(0, 1));
      #1;
      check_zero("in_reset");
    end
    release_with(0, 100, 1'b1);
    drive(0, 100, 1'b1, 1'b0, 1'b0);

    // Directed points: strip start, last tile address, just below strip, transparent index.
    drive(5, 416, 1'b1, 1'b0, 1'b0);
    drive(63, 447, 1'b1, 1'b0, 1'b0);
    drive(63, 448, 1'b1, 1'b0, 1'b0);
    drive(6, 417, 1'b1, 1'b0, 1'b0);
    drive(10, 420, 1'b0, 1'b0, 1'b0);

`ifdef GRASS_SCROLL_EN
    // 63 frame edges wrap col for DrawX=1 to 0; one more returns scroll to 0.
    for (int i = 0; i < 63; i++) begin
      drive(0, 0, 1'b0, 1'b1, 1'b1);
      drive(0, 0, 1'b0, 1'b0, 1'b1);
    end
    drive(1, 416, 1'b1, 1'b0, 1'b1);
    drive(0, 0, 1'b0, 1'b1, 1'b1);
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    drive(5, 416, 1'b1, 1'b0, 1'b1);
    // Held-high frame_clk advances once only.
    for (int i = 0; i < 10; i++) drive(5, 416, 1'b1, 1'b1, 1'b1);
    drive(5, 416, 1'b1, 1'b0, 1'b1);
    drive(5, 416, 1'b1, 1'b0, 1'b1);
`endif

    // Random traffic around the strip boundaries.
    for (int i = 0; i < 400; i++) begin
      drive(int'($urandom_range(0, 1023)), int'($urandom_range(400, 460)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    // Back-to-back sweep of a strip row with a reset dropped in the middle.
    for (int x = 0; x < 640; x++) begin
      if (x == 320) begin
        enter_reset("mid_sweep");
        @(posedge Clk);
        #1;
        check_zero("mid_sweep_hold");
        release_with(x, 420, 1'b1);
      end else begin
        drive(x, 420, 1'b1, 1'b0, 1'b0);
      end
    end
    drive(0, 0, 1'b0, 1'b0, 1'b0);

    repeat (4) @(posedge Clk);
    #1;
    chk("drain_addr_q", addr_q.size(), 0);
    chk("drain_out_q", out_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/grass_pixel_fetch.md
Name: grass_pixel_fetch

Overview:
Upstream feeder of the grass colour-palette stage. It converts the VGA controller's current pixel coordinates into an address for the grass tile ROM and captures the returned 4-bit palette index. It presents that index, a pixel-valid flag and a grass-region flag to the palette lookup. It also maintains a per-frame horizontal scroll offset so the grass strip can drift across the screen.

Parameters:
TILE_W, 64, tile width in pixels; power of two; tile repeats horizontally.
TILE_H, 32, tile height in pixels; power of two.
GRASS_Y_TOP, 416, first screen row of the grass strip.
SCROLL_STEP, 1, pixels added to the scroll offset per frame; must be less than TILE_W.
ADDR_W, 11, ROM address width; equals log2(TILE_W*TILE_H).

Ports:
Clk  in  1  system/pixel clock.
Reset_n  in  1  asynchronous, active-low reset.
DrawX  in  10  current pixel column from the VGA controller.
DrawY  in  10  current pixel row from the VGA controller.
blank_n  in  1  high during the visible area.
frame_clk  in  1  vertical sync level, synchronous to Clk; each rising edge marks a new frame.
scroll_en  in  1  enables scroll advance.
rom_addr  out  ADDR_W  registered address to the synchronous tile ROM.
rom_data  in  4  ROM read data, valid one cycle after rom_addr.
color_idx  out  4  palette index to the palette stage.
grass_on  out  1  pixel lies in the strip and its index is non-transparent.
pix_valid  out  1  color_idx corresponds to a visible pixel.

Behaviour:
- Reset (Reset_n low, asynchronous): the following are all 0:
  - rom_addr, color_idx, grass_on, pix_valid;
  - scroll_x;
  - the frame_clk edge register;
  - all pipeline valid and region bits.
- Region test: in_strip = blank_n AND (DrawY >= GRASS_Y_TOP) AND (DrawY < GRASS_Y_TOP+TILE_H).
- Address arithmetic:
  - row = (DrawY - GRASS_Y_TOP), truncated to log2(TILE_H) bits.
  - col = (DrawX + scroll_x) mod TILE_W, taken from the low log2(TILE_W) bits; this handles wrap-around.
  - addr = row*TILE_W + col, implemented as concatenation {row, col}.
- Stage 1 (edge N+1):
  - rom_addr <= in_strip ? addr : 0.
  - v1 <= blank_n; r1 <= in_strip.
- Stage 2 (edge N+2):
  - rom_data is valid this cycle.
  - v2 <= v1; r2 <= r1; idx2 <= r1 ? rom_data : 0.
- Outputs:
  - color_idx = idx2; pix_valid = v2.
  - grass_on = r2 AND (idx2 != 0).
  - Index 0 is the transparent index.
- Latency:
  - Coordinates sampled at edge N appear on color_idx after edge N+2, i.e. 2 cycles.
  - Steady-state throughput is one pixel per clock, with no stalls.
- Outside the strip or in blanking:
  - rom_addr = 0, color_idx = 0, grass_on = 0.
  - pix_valid follows the delayed blank_n.
- Scroll (feature enabled):
  - fc_d <= frame_clk each cycle; frame_tick = frame_clk AND NOT fc_d.
  - On frame_tick with scroll_en = 1: scroll_x <= (scroll_x + SCROLL_STEP) mod TILE_W.
  - scroll_x updates only on frame_tick, so it is constant for the whole visible frame.
- Simultaneous events:
  - A frame_tick in the same cycle as a visible pixel affects addresses from the next cycle onward; the pipeline is unaffected.
  - frame_clk held high produces one tick only.
- Reset mid-frame:
  - Pipeline is flushed and scroll_x returns to 0.
  - The first pix_valid after release comes two cycles after blank_n is sampled high.

Optional Feature:
GRASS_SCROLL_EN:
- Defined: scroll_x counter and frame_clk edge detection are present, as described above.
- Undefined: scroll_x is a constant 0, scroll_en and frame_clk are ignored, and col = DrawX mod TILE_W; no scroll registers are synthesised.

Test Plan:
1. Reset_n low while inputs toggle -> all outputs 0; release with DrawY=100, blank_n=1 -> pix_valid=1 two cycles later, grass_on=0, color_idx=0, rom_addr=0.
2. DrawY=416, DrawX=5, scroll_x=0, ROM model returns 4'h4 -> rom_addr=5 at N+1; color_idx=4, grass_on=1 at N+2.
3. DrawY=447, DrawX=63 -> rom_addr=2047; DrawY=448 -> grass_on=0 and rom_addr=0.
4. ROM returns 0 for address 70 (DrawY=417, DrawX=6) -> color_idx=0, grass_on=0, pix_valid=1.
5. GRASS_SCROLL_EN defined, scroll_en=1:
   - 63 frame_clk rising edges, then DrawX=1, DrawY=416 -> scroll_x=63, rom_addr=0 (wrap).
   - One more edge -> scroll_x=0.
   - frame_clk held high for 10 cycles -> exactly one increment.
6. Continuous sweep DrawX=0..639 at DrawY=420 -> one output per clock, each color_idx matching the ROM model at {4, DrawX mod 64} two cycles later; assert Reset_n low mid-sweep -> outputs 0 immediately.
